// File: rtl/uart_rx_multi_pkg.sv
// Shared types and constants for the uart_rx_multi receiver.
// Holds the FSM state encoding, the latched per-frame configuration payload,
// the prescale/data-length limits and the parity helper.
// Optional feature macro: UART_RX_BREAK_DET_EN adds the BRK_WAIT state.
package uart_rx_multi_pkg;

  localparam int unsigned PRESCALE_MIN = 8;
  localparam int unsigned PRESCALE_MAX = 32;
  localparam int unsigned DATA_LEN_MIN = 5;
  localparam int unsigned CNT_W        = 6;   // bit-period arithmetic width
  localparam int unsigned BIT_CNT_W    = 4;   // start + 9 data + parity + 2 stop fits
  localparam int unsigned LEN_W        = 4;
  localparam int unsigned PAR_W        = 16;  // parity helper input width

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_DONE
`ifdef UART_RX_BREAK_DET_EN
    , S_BRK_WAIT
`endif
  } state_e;

  // Frame configuration captured at the start bit.
  typedef struct packed {
    logic             par_en;
    logic             par_typ;
    logic             stop2;
    logic [LEN_W-1:0] data_len;
    logic [CNT_W-1:0] prescale;
  } rx_cfg_t;

  // Even parity of a zero-extended data word.
  function automatic logic even_parity(input logic [PAR_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing front end of uart_rx_multi.
// Ports: clk/rst_n (sync active-low); rx_in raw line; en runs the counters
// (held at 0 otherwise); prescale = CLK cycles per bit.
// Outputs: rx_s synchronised line; bit_valid_c/bit_val_c majority decision
// at edge P/2+1; bit_wrap_c at edge P-1; bit_cnt = wraps since en rose.
module uart_rx_sampler
  import uart_rx_multi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 en,
  input  logic [CNT_W-1:0]     prescale,
  output logic                 rx_s,
  output logic                 bit_valid_c,
  output logic                 bit_val_c,
  output logic                 bit_wrap_c,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 smp0_q, smp0_d;
  logic                 smp1_q, smp1_d;
  logic [CNT_W-1:0]     half, mid_lo, mid_hi, last;

  assign half   = prescale >> 1;
  assign mid_lo = half - CNT_W'(1);
  assign mid_hi = half + CNT_W'(1);
  assign last   = prescale - CNT_W'(1);

  assign rx_s    = sync2_q;
  assign bit_cnt = bit_cnt_q;

  // Counters, sample capture and the majority vote (third sample is live).
  always_comb begin
    sync1_d     = rx_in;
    sync2_d     = sync1_q;
    edge_cnt_d  = edge_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    smp0_d      = smp0_q;
    smp1_d      = smp1_q;
    bit_wrap_c  = en && (edge_cnt_q == last);
    bit_valid_c = en && (edge_cnt_q == mid_hi);
    bit_val_c   = (smp0_q & smp1_q) | (smp0_q & sync2_q) | (smp1_q & sync2_q);
    if (!en) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      if (edge_cnt_q == mid_lo) smp0_d = sync2_q;
      if (edge_cnt_q == half)   smp1_d = sync2_q;
      if (bit_wrap_c) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      smp0_q     <= 1'b0;
      smp1_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      smp0_q     <= smp0_d;
      smp1_q     <= smp1_d;
    end
  end

endmodule

// File: rtl/uart_rx_multi.sv
// Configurable UART receiver with a valid/ready holding register.
// Ports: CLK, RST (sync active-low), RX_IN serial line; PAR_EN/PAR_TYP/STOP2/
// DATA_LEN/Prescale frame format (latched at start bit); DATA_READY sink
// accept. Outputs (registered): P_DATA/DATA_VALID held word, Parity_Error,
// Stop_Error, Overrun_Error, Break_Det one-cycle pulses.
// Optional feature macro: UART_RX_BREAK_DET_EN (break detect + BRK_WAIT).
module uart_rx_multi
  import uart_rx_multi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [LEN_W-1:0]      DATA_LEN,
  input  logic [CNT_W-1:0]      Prescale,
  input  logic                  DATA_READY,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic                  Overrun_Error,
  output logic                  Break_Det
);

  state_e                state_q, state_d;
  rx_cfg_t               cfg_q, cfg_d, cfg_c;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  frm_perr_q, frm_perr_d;
  logic                  frm_serr_q, frm_serr_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  ovr_err_q, ovr_err_d;
  logic                  rx_s, bit_valid_c, bit_val_c, bit_wrap_c, en_c;
  logic [BIT_CNT_W-1:0]  bit_cnt;
`ifdef UART_RX_BREAK_DET_EN
  logic                  all_zero_q, all_zero_d;
  logic                  brk_q, brk_d;
  logic                  brk_det_q, brk_det_d;
`endif

  assign en_c = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_PARITY) ||
                (state_q == S_STOP1) || (state_q == S_STOP2);

  uart_rx_sampler u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .rx_in       (RX_IN),
    .en          (en_c),
    .prescale    (cfg_q.prescale),
    .rx_s        (rx_s),
    .bit_valid_c (bit_valid_c),
    .bit_val_c   (bit_val_c),
    .bit_wrap_c  (bit_wrap_c),
    .bit_cnt     (bit_cnt)
  );

  // Clamp the live configuration into the supported range.
  always_comb begin
    cfg_c.par_en  = PAR_EN;
    cfg_c.par_typ = PAR_TYP;
    cfg_c.stop2   = STOP2;
    if (DATA_LEN < LEN_W'(DATA_LEN_MIN))     cfg_c.data_len = LEN_W'(DATA_LEN_MIN);
    else if (DATA_LEN > LEN_W'(DATA_WIDTH))  cfg_c.data_len = LEN_W'(DATA_WIDTH);
    else                                     cfg_c.data_len = DATA_LEN;
    if (Prescale < CNT_W'(PRESCALE_MIN))     cfg_c.prescale = CNT_W'(PRESCALE_MIN);
    else if (Prescale > CNT_W'(PRESCALE_MAX)) cfg_c.prescale = CNT_W'(PRESCALE_MAX);
    else                                     cfg_c.prescale = {Prescale[CNT_W-1:1], 1'b0};
  end

  // Frame FSM and holding-register control.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    shift_d      = shift_q;
    frm_perr_d   = frm_perr_q;
    frm_serr_d   = frm_serr_q;
    p_data_d     = p_data_q;
    data_valid_d = data_valid_q && !DATA_READY;
    par_err_d    = 1'b0;
    stop_err_d   = 1'b0;
    ovr_err_d    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    all_zero_d   = all_zero_q;
    brk_d        = brk_q;
    brk_det_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cfg_d      = cfg_c;
          shift_d    = '0;
          frm_perr_d = 1'b0;
          frm_serr_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          all_zero_d = 1'b1;
          brk_d      = 1'b0;
`endif
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_valid_c && bit_val_c) state_d = S_IDLE;
        else if (bit_wrap_c)          state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_valid_c) begin
          // Data bit i is the (i+1)-th bit period after the start bit.
          for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt == BIT_CNT_W'(i + 1)) shift_d[i] = bit_val_c;
          end
`ifdef UART_RX_BREAK_DET_EN
          if (bit_val_c) all_zero_d = 1'b0;
`endif
        end
        if (bit_wrap_c && (bit_cnt == cfg_q.data_len))
          state_d = cfg_q.par_en ? S_PARITY : S_STOP1;
      end
      S_PARITY: begin
        if (bit_valid_c) begin
          if (bit_val_c != (even_parity(PAR_W'(shift_q)) ^ cfg_q.par_typ)) frm_perr_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          if (bit_val_c) all_zero_d = 1'b0;
`endif
        end
        if (bit_wrap_c) state_d = S_STOP1;
      end
      S_STOP1: begin
        // The final stop bit leaves at its decision edge so a following
        // start bit can be caught inside the rest of the stop period.
        if (bit_valid_c) begin
          if (!bit_val_c) begin
`ifdef UART_RX_BREAK_DET_EN
            if (all_zero_q) brk_d = 1'b1;
            else            frm_serr_d = 1'b1;
`else
            frm_serr_d = 1'b1;
`endif
          end
          if (!cfg_q.stop2) state_d = S_DONE;
`ifdef UART_RX_BREAK_DET_EN
          if (!bit_val_c && all_zero_q) state_d = S_DONE;
`endif
        end else if (bit_wrap_c && cfg_q.stop2) begin
          state_d = S_STOP2;
        end
      end
      S_STOP2: begin
        if (bit_valid_c) begin
          if (!bit_val_c) frm_serr_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
        if (brk_q) begin
          brk_det_d = 1'b1;
          state_d   = S_BRK_WAIT;
        end else
`endif
        if (frm_perr_q || frm_serr_q) begin
          par_err_d  = frm_perr_q;
          stop_err_d = frm_serr_q;
        end else if (data_valid_q && !DATA_READY) begin
          ovr_err_d = 1'b1;
        end else begin
          p_data_d     = shift_q;
          data_valid_d = 1'b1;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      S_BRK_WAIT: begin
        if (rx_s) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      cfg_q        <= '0;
      shift_q      <= '0;
      frm_perr_q   <= 1'b0;
      frm_serr_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      ovr_err_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      all_zero_q   <= 1'b0;
      brk_q        <= 1'b0;
      brk_det_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      shift_q      <= shift_d;
      frm_perr_q   <= frm_perr_d;
      frm_serr_q   <= frm_serr_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
      ovr_err_q    <= ovr_err_d;
`ifdef UART_RX_BREAK_DET_EN
      all_zero_q   <= all_zero_d;
      brk_q        <= brk_d;
      brk_det_q    <= brk_det_d;
`endif
    end
  end

  assign P_DATA        = p_data_q;
  assign DATA_VALID    = data_valid_q;
  assign Parity_Error  = par_err_q;
  assign Stop_Error    = stop_err_q;
  assign Overrun_Error = ovr_err_q;
`ifdef UART_RX_BREAK_DET_EN
  assign Break_Det     = brk_det_q;
`else
  assign Break_Det     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_multi.sv
// Self-checking bench for uart_rx_multi: directed scenarios followed by
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_multi;

  localparam int unsigned DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic [3:0]    DATA_LEN = 4'd8;
  logic [5:0]    Prescale = 6'd8;
  logic          DATA_READY = 1'b1;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID, Parity_Error, Stop_Error, Overrun_Error, Break_Det;

  always #5 CLK = ~CLK;

  uart_rx_multi #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .DATA_LEN(DATA_LEN), .Prescale(Prescale), .DATA_READY(DATA_READY),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .Parity_Error(Parity_Error),
    .Stop_Error(Stop_Error), .Overrun_Error(Overrun_Error), .Break_Det(Break_Det)
  );

  // Output monitor: pulse counters and accepted words (sampled mid-cycle).
  int unsigned   n_perr = 0, n_serr = 0, n_ovr = 0, n_brk = 0;
  logic [DW-1:0] got_w [0:1023];
  logic [9:0]    got_n = '0;

  always @(negedge CLK) begin
    if (Parity_Error)  n_perr++;
    if (Stop_Error)    n_serr++;
    if (Overrun_Error) n_ovr++;
    if (Break_Det)     n_brk++;
    if (DATA_VALID && DATA_READY) begin
      got_w[got_n] = P_DATA;
      got_n = got_n + 10'd1;
    end
  end

  int unsigned checks = 0, errors = 0;
  int unsigned s_perr, s_serr, s_ovr, s_brk;
  logic [9:0]  s_n, rd_idx = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    s_perr = n_perr; s_serr = n_serr; s_ovr = n_ovr; s_brk = n_brk; s_n = got_n;
  endtask

  task automatic check_deltas(input string tag, input int perr, input int serr,
                              input int ovr, input int brk, input int words);
    check({tag, ".perr"},  32'(n_perr - s_perr), 32'(perr));
    check({tag, ".serr"},  32'(n_serr - s_serr), 32'(serr));
    check({tag, ".ovr"},   32'(n_ovr - s_ovr),   32'(ovr));
    check({tag, ".brk"},   32'(n_brk - s_brk),   32'(brk));
    check({tag, ".words"}, 32'(got_n - s_n),     32'(words));
  endtask

  task automatic check_word(input string tag, input logic [8:0] exp);
    check(tag, 32'(got_w[rd_idx]), 32'(exp));
    rd_idx = rd_idx + 10'd1;
  endtask

  // Reference model: effective length and delivered word from the frame rules.
  function automatic int eff_len(input logic [3:0] raw);
    if (int'(raw) < 5)  return 5;
    if (int'(raw) > DW) return DW;
    return int'(raw);
  endfunction

  function automatic logic [8:0] model_word(input logic [8:0] d, input logic [3:0] raw);
    logic [8:0] mask;
    mask = (9'd1 << eff_len(raw)) - 9'd1;
    return d & mask;
  endfunction

  // Drive one frame; leaves the line idle high afterwards.
  task automatic send_frame(input logic [8:0] d, input logic [3:0] raw_len, input logic pe,
                            input logic pt, input logic s2, input int p, input logic bad_par,
                            input logic bad_stop, input int gl_bit, input int gl_off);
    logic [15:0] fr;
    logic [8:0]  w;
    int          nb;
    w = model_word(d, raw_len);
    PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; DATA_LEN = raw_len; Prescale = 6'(p);
    fr = '0;
    nb = 1;
    for (int i = 0; i < eff_len(raw_len); i++) begin fr[nb] = w[i]; nb++; end
    if (pe) begin fr[nb] = (^w) ^ pt ^ bad_par; nb++; end
    fr[nb] = ~bad_stop; nb++;
    if (s2) begin fr[nb] = 1'b1; nb++; end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < p; c++) begin
        RX_IN = fr[b] ^ ((b == gl_bit && c == gl_off) ? 1'b1 : 1'b0);
        tick(1);
      end
    end
    RX_IN = 1'b1;
  endtask

  logic [8:0] exp_q[$];
  int unsigned exp_perr;

  initial begin
    // Reset values
    tick(3);
    check("rst.p_data", 32'(P_DATA), 32'h0);
    check("rst.valid", 32'(DATA_VALID), 32'h0);
    check("rst.flags", {28'h0, Parity_Error, Stop_Error, Overrun_Error, Break_Det}, 32'h0);
    RST = 1'b1;
    tick(5);

    // 8N1, P=8, 0xA5
    snap();
    send_frame(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1, 0);
    tick(8);
    check_deltas("a5", 0, 0, 0, 0, 1);
    check_word("a5.word", 9'h0A5);

    // 7E2, P=16, 0x35 with flipped parity
    snap();
    send_frame(9'h035, 4'd7, 1'b1, 1'b0, 1'b1, 16, 1'b1, 1'b0, -1, 0);
    tick(10);
    check_deltas("par", 1, 0, 0, 0, 0);
    check("par.valid", 32'(DATA_VALID), 32'h0);

    // 2-cycle low glitch on idle line
    snap();
    PAR_EN = 1'b0; STOP2 = 1'b0; DATA_LEN = 4'd8; Prescale = 6'd8;
    RX_IN = 1'b0; tick(2); RX_IN = 1'b1;
    tick(40);
    check_deltas("glitch", 0, 0, 0, 0, 0);

    // 1-cycle glitch at centre of data bit 3 of 0x00
    snap();
    send_frame(9'h000, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 4, 5);
    tick(8);
    check_deltas("mid", 0, 0, 0, 0, 1);
    check_word("mid.word", 9'h000);

    // Overrun: sink stalled, back-to-back 0x11 then 0x22
    snap();
    DATA_READY = 1'b0;
    send_frame(9'h011, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1, 0);
    send_frame(9'h022, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1, 0);
    tick(8);
    check_deltas("ovr", 0, 0, 1, 0, 0);
    check("ovr.valid", 32'(DATA_VALID), 32'h1);
    check("ovr.held", 32'(P_DATA), 32'h11);
    DATA_READY = 1'b1;
    tick(1);
    check("ovr.drop", 32'(DATA_VALID), 32'h0);
    check_word("ovr.word", 9'h011);

    // Stop bit low on 0x5A
    snap();
    send_frame(9'h05A, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, -1, 0);
    tick(10);
    check_deltas("stop", 0, 1, 0, 0, 0);

    // All-zero frame with a low stop sample
    snap();
`ifdef UART_RX_BREAK_DET_EN
    RX_IN = 1'b0;
    tick(10 * 8 + 40);
    check_deltas("brk", 0, 0, 0, 1, 0);
    RX_IN = 1'b1;
    tick(10);
    check_deltas("brk.wait", 0, 0, 0, 1, 0);
`else
    send_frame(9'h000, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, -1, 0);
    tick(20);
    check_deltas("brk", 0, 1, 0, 0, 0);
`endif

    // Reset in the middle of DATA, then a clean 0x3C
    PAR_EN = 1'b0; STOP2 = 1'b0; DATA_LEN = 4'd8; Prescale = 6'd8;
    RX_IN = 1'b0; tick(8);
    tick(16);
    RX_IN = 1'b1; tick(8);
    RST = 1'b0;
    tick(3);
    check("mrst.p_data", 32'(P_DATA), 32'h0);
    check("mrst.out", {27'h0, DATA_VALID, Parity_Error, Stop_Error, Overrun_Error, Break_Det}, 32'h0);
    RST = 1'b1;
    tick(10);
    snap();
    send_frame(9'h03C, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, -1, 0);
    tick(8);
    check_deltas("post", 0, 0, 0, 0, 1);
    check_word("post.word", 9'h03C);

    // Randomized frames, some back-to-back, some with bad parity
    snap();
    exp_perr = 0;
    for (int k = 0; k < 40; k++) begin
      logic [8:0] d;
      logic [3:0] raw;
      logic       pe, pt, s2, bp;
      int         p;
      d   = 9'($urandom);
      raw = 4'($urandom_range(0, 15));
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      s2  = 1'($urandom);
      p   = 2 * int'($urandom_range(4, 16));
      bp  = pe && ($urandom_range(0, 5) == 0);
      if (bp) exp_perr++;
      else    exp_q.push_back(model_word(d, raw));
      send_frame(d, raw, pe, pt, s2, p, bp, 1'b0, -1, 0);
      tick(int'($urandom_range(0, 3)));
    end
    tick(80);
    check("rnd.perr", 32'(n_perr - s_perr), 32'(exp_perr));
    check("rnd.serr", 32'(n_serr - s_serr), 32'h0);
    check("rnd.ovr", 32'(n_ovr - s_ovr), 32'h0);
    check("rnd.words", 32'(got_n - s_n), 32'(exp_q.size()));
    while (exp_q.size() > 0) check_word("rnd.word", exp_q.pop_front());
    check("end.brk_total", 32'(n_brk),
`ifdef UART_RX_BREAK_DET_EN
          32'h1);
`else
          32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_multi.md
# uart_rx_multi

Parametrised successor UART receiver for the serial-in path of the low-power multi-clock system. It supports a runtime data length, optional parity, one or two stop bits, and 3-sample majority-vote bit decisions. Received words are presented through a valid/ready holding register with overrun detection, so the sink may stall. The block sits in the UART clock domain, between the pad-side RX_IN and the RX-side synchroniser/FIFO.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame; legal range 5..9.
- CLK  in  1  UART oversampling clock.
- RST  in  1  synchronous active-low reset.
- RX_IN  in  1  asynchronous serial line; idles high.
- PAR_EN  in  1  1 = a parity bit follows the data.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  1 = two stop bits.
- DATA_LEN  in  4  number of data bits; values below 5 are treated as 5, values above DATA_WIDTH as DATA_WIDTH.
- Prescale  in  6  CLK cycles per bit; even values 8..32 only.
- DATA_READY  in  1  sink accepts P_DATA while DATA_VALID is high.
- P_DATA  out  DATA_WIDTH  received word, LSB first on the line; bits at DATA_LEN and above are 0.
- DATA_VALID  out  1  holding register full.
- Parity_Error  out  1  1-cycle pulse.
- Stop_Error  out  1  1-cycle pulse.
- Overrun_Error  out  1  1-cycle pulse.
- Break_Det  out  1  1-cycle pulse; tied to 0 without the macro.

## Operation
- RX_IN passes through a 2-flop synchroniser (reset value 1) to produce rx_s. All decisions below use rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, plus BRK_WAIT when the macro is defined.
- IDLE: when rx_s = 0, latch PAR_EN, PAR_TYP, STOP2, the clamped DATA_LEN and Prescale, then go to START. Changes to these inputs mid-frame are ignored.
- Edge counter: runs 0..Prescale-1 and wraps; the bit counter increments on each wrap.
- Sampling: rx_s is sampled at edges P/2-1, P/2 and P/2+1. The bit value is the majority of the three, decided at edge P/2+1.
- START: if the decided start bit is 1, treat it as a glitch and return to IDLE with no flags. Otherwise go to DATA at the bit-period wrap.
- DATA: shift each decided bit into a shift register, LSB first. After DATA_LEN bits go to PARITY if PAR_EN, else STOP1.
- PARITY: compute even parity = XOR of the data bits; odd parity = its inverse. Compare against the received parity bit.
- STOP1: the stop bit must be 1. If STOP2, continue to STOP2, which must also be 1.
- The final stop bit advances to DONE at its decision edge (P/2+1), not at the bit wrap. This lets a following start bit be detected within the remainder of the stop period.
- DONE lasts one cycle, then returns to IDLE. Actions, in priority order:
  - Parity or stop error: pulse the matching flag(s); discard the word.
  - Otherwise, DATA_VALID already high and DATA_READY low: pulse Overrun_Error; discard the new word; the held word is kept.
  - Otherwise: load P_DATA and set DATA_VALID.
- Handshake: DATA_VALID clears on the cycle after DATA_VALID & DATA_READY. If DONE coincides with acceptance, the new word is loaded, DATA_VALID stays high and there is no overrun.
- Reset value of every output is 0; the FSM resets to IDLE and the counters to 0. Reset mid-frame abandons the frame with no flags.

## Timing
- RX_IN to rx_s: 2 cycles.
- rx_s falling edge to START entry: 1 cycle.
- The DONE cycle is 1 cycle after the final stop-bit decision edge. Error/overrun pulses and DATA_VALID rising occur together on the cycle after DONE.
- Minimum frame spacing: back-to-back frames with zero idle must be received without loss.
- Bit-period arithmetic uses 6-bit unsigned values. P/2 is computed as Prescale >> 1.

## Configuration
- UART_RX_BREAK_DET_EN defined:
  - A frame whose data bits, parity bit (if enabled) and first stop sample are all 0 pulses Break_Det instead of Stop_Error. No word is delivered.
  - The FSM then waits in BRK_WAIT until rx_s = 1 before returning to IDLE.
- UART_RX_BREAK_DET_EN undefined:
  - The same frame is reported as Stop_Error. The FSM returns to IDLE, where the held-low line is seen as a new start.
  - Break_Det is tied to 0.

## Structure
- Package uart_rx_multi_pkg holds:
  - the state encoding,
  - PRESCALE_MIN/MAX (8/32),
  - DATA_LEN_MIN (5),
  - a parity function.
- Sub-module uart_rx_sampler contains:
  - the synchroniser,
  - the edge and bit counters,
  - the 3-sample majority vote.
- It outputs bit_valid and bit_val to the FSM.

## Test plan
- 8N1, Prescale 8, byte 0xA5, DATA_READY high: DATA_VALID pulses with P_DATA=0xA5; no flags.
- 7E2, Prescale 16, 0x35 with a wrong parity bit: Parity_Error pulses once; DATA_VALID stays 0.
- 8N1, 2-cycle low glitch on idle RX_IN: no flags and no DATA_VALID. A 1-cycle glitch on the centre sample of data bit 3 of 0x00: P_DATA=0x00.
- DATA_READY held low, two back-to-back frames 0x11 then 0x22: P_DATA=0x11 is held and Overrun_Error pulses once. After acceptance DATA_VALID drops.
- Stop bit driven 0 on 0x5A: Stop_Error pulses. An all-zero frame with the macro defined: Break_Det pulses, and no new start is detected until RX_IN returns high.
- Reset asserted mid-DATA, then released: all outputs 0. The next clean frame 0x3C is received correctly.
